alu_issue_ctrl: RTL and testbench

//  Issue controller in front of the integer ALU. Accepts one decoded instruction per

---
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue controller in front of the integer ALU. Accepts one decoded
//            instruction per cycle (valid/ready), steers single-cycle ops and
//            pipelined MULs onto the datapath, tracks in-flight MULs in a shift
//            chain and drives the single register-file writeback port.
// Ports    : clk_i        clock, rising edge
//            rsn_i        asynchronous active-low reset
//            valid_i      instr_i holds a valid instruction
//            instr_i      RV64I/M instruction word
//            ready_o      instruction accepted when valid_i & ready_o
//            alu_issue_o  single-cycle op issued this cycle
//            mul_issue_o  MUL issued this cycle
//            wb_valid_o   register-file write this cycle
//            wb_rd_o      destination register of the write
//            wb_sel_o     0 = ALU result, 1 = MUL pipeline result
//            busy_o       at least one MUL in flight
// Params   : MUL_LAT      MUL issue-to-writeback latency, must be >= 2
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  output logic        ready_o,
  output logic        alu_issue_o,
  output logic        mul_issue_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_sel_o,
  output logic        busy_o
);

  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_f7_muldiv = 7'b0000001;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_mul;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_writes_rd;

  assign w_opcode = instr_i[6:0];
  assign w_rd     = instr_i[11:7];
  assign w_funct3 = instr_i[14:12];
  assign w_rs1    = instr_i[19:15];
  assign w_rs2    = instr_i[24:20];
  assign w_funct7 = instr_i[31:25];

  // Only the plain MUL goes down the pipelined path; the other M-extension
  // encodings are treated as single-cycle ops by this controller.
  assign w_is_mul    = (w_opcode == c_op_reg) && (w_funct3 == 3'b000) &&
                       (w_funct7 == c_f7_muldiv);
  assign w_uses_rs1  = (w_opcode != c_op_jal);
  assign w_uses_rs2  = (w_opcode == c_op_reg) || (w_opcode == c_op_store) ||
                       (w_opcode == c_op_branch);
  assign w_writes_rd = (w_opcode == c_op_reg)  || (w_opcode == c_op_imm) ||
                       (w_opcode == c_op_load) || (w_opcode == c_op_jal);

  // ---------------------------------------------------------------------------
  // In-flight MUL chain: stage k holds the MUL issued k+1 cycles ago.
  // The last stage is the one writing back this cycle.
  // ---------------------------------------------------------------------------
  logic [MUL_LAT-1:0]      r_s_vld;
  logic [MUL_LAT-1:0][4:0] r_s_rd;

  // Single-cycle result register feeding the writeback port one cycle later.
  logic       r_alu_vld;
  logic [4:0] r_alu_rd;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic w_raw;
  logic w_waw;
  logic w_wb_conflict;
  logic w_stall;
  logic w_accept;

  always_comb begin
    w_raw = 1'b0;
    w_waw = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      if (r_s_vld[k]) begin
        // No MUL bypass exists, so even the stage writing back this cycle
        // blocks a consumer.
        if (w_uses_rs1 && (w_rs1 != 5'd0) && (w_rs1 == r_s_rd[k])) begin
          w_raw = 1'b1;
        end
        if (w_uses_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_s_rd[k])) begin
          w_raw = 1'b1;
        end
        if (w_writes_rd && (w_rd != 5'd0) && (w_rd == r_s_rd[k])) begin
          w_waw = 1'b1;
        end
      end
    end
  end

  // A single-cycle writer issued now would write back next cycle, exactly when
  // the MUL in the second-to-last stage reaches the port.
  assign w_wb_conflict = !w_is_mul && w_writes_rd && r_s_vld[MUL_LAT-2];
  assign w_stall       = w_wb_conflict || w_raw || w_waw;

  // The hazard rules only apply to a presented instruction; with nothing
  // offered the controller advertises readiness.
  assign ready_o     = rsn_i && !(valid_i && w_stall);
  assign w_accept    = valid_i && ready_o;
  assign mul_issue_o = w_accept && w_is_mul;
  assign alu_issue_o = w_accept && !w_is_mul;

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_s_vld   <= '0;
      r_s_rd    <= '0;
      r_alu_vld <= 1'b0;
      r_alu_rd  <= 5'd0;
    end else begin
      r_s_vld   <= {r_s_vld[MUL_LAT-2:0], mul_issue_o};
      r_s_rd    <= {r_s_rd[MUL_LAT-2:0], w_rd};
      r_alu_vld <= alu_issue_o && w_writes_rd;
      r_alu_rd  <= w_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback port: the hazard rules guarantee the two sources never collide.
  // ---------------------------------------------------------------------------
  assign wb_sel_o   = r_s_vld[MUL_LAT-1];
  assign wb_valid_o = r_alu_vld || r_s_vld[MUL_LAT-1];
  assign wb_rd_o    = r_s_vld[MUL_LAT-1] ? r_s_rd[MUL_LAT-1] :
                      (r_alu_vld ? r_alu_rd : 5'd0);
  assign busy_o     = |r_s_vld;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. A reference model tracks
//            in-flight MULs by their writeback cycle; accepted instructions push
//            expected writebacks into a scoreboard that a monitor process drains.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int L = 3;

  logic        clk_i;
  logic        rsn_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic        ready_o;
  logic        alu_issue_o;
  logic        mul_issue_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_sel_o;
  logic        busy_o;

  alu_issue_ctrl #(.MUL_LAT(L)) dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .valid_i     (valid_i),
    .instr_i     (instr_i),
    .ready_o     (ready_o),
    .alu_issue_o (alu_issue_o),
    .mul_issue_o (mul_issue_o),
    .wb_valid_o  (wb_valid_o),
    .wb_rd_o     (wb_rd_o),
    .wb_sel_o    (wb_sel_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  longint cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int rd; int sel; longint cyc; } wb_t;
  typedef struct { int rd; longint wb; } mul_t;
  wb_t  exp_q[$];
  mul_t mq[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Instruction encoders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] i_mul(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return enc(7'b0000001, b, a, 3'b000, rd, 7'b0110011);
  endfunction

  function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return enc(7'b0000000, b, a, 3'b000, rd, 7'b0110011);
  endfunction

  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
    return {imm, a, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    int          c;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    c   = $urandom_range(0, 7);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    f7  = 7'($urandom_range(0, 127));
    case (c)
      0, 1: begin op = 7'b0110011; f7 = 7'b0000001; f3 = 3'b000; end
      2:    begin op = 7'b0110011; f7 = ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'b0000000; end
      3:    op = 7'b0010011;
      4:    op = 7'b0000011;
      5:    op = 7'b1101111;
      6:    op = 7'b0100011;
      default: op = 7'b1100011;
    endcase
    return enc(f7, rs2, rs1, f3, rd, op);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one cycle of stimulus plus same-cycle checks. A MUL that
  // writes back at cycle W occupies the pipeline during cycles W-L+1 .. W.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [31:0] ins, output bit acc);
    longint now;
    bit     busy, raw, waw, conf, is_mul, writes, u1, u2, rdy;
    int     op, rd, rs1, rs2;
    @(posedge clk_i);
    #1;
    valid_i = v;
    instr_i = ins;
    @(negedge clk_i);
    now = cyc;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].wb < now) mq.delete(i);
    op     = int'(ins[6:0]);
    rd     = int'(ins[11:7]);
    rs1    = int'(ins[19:15]);
    rs2    = int'(ins[24:20]);
    is_mul = (op == 'h33) && (ins[14:12] == 3'd0) && (ins[31:25] == 7'd1);
    writes = (op == 'h33) || (op == 'h13) || (op == 'h03) || (op == 'h6F);
    u1     = (op != 'h6F);
    u2     = (op == 'h33) || (op == 'h23) || (op == 'h63);
    busy = 0; raw = 0; waw = 0; conf = 0;
    foreach (mq[i]) begin
      if (mq[i].wb <= now + L - 1) begin
        busy = 1;
        if (u1 && rs1 != 0 && rs1 == mq[i].rd) raw = 1;
        if (u2 && rs2 != 0 && rs2 == mq[i].rd) raw = 1;
        if (writes && rd != 0 && rd == mq[i].rd) waw = 1;
      end
      if (mq[i].wb == now + 1) conf = 1;
    end
    rdy = v ? !(raw || waw || (conf && writes && !is_mul)) : 1'b1;
    acc = v && rdy;
    chk("ready", ready_o, rdy);
    chk("alu_issue", alu_issue_o, acc && !is_mul);
    chk("mul_issue", mul_issue_o, acc && is_mul);
    chk("busy", busy_o, busy);
    if (acc) begin
      if (is_mul) begin
        mq.push_back('{rd, now + L});
        exp_q.push_back('{rd, 1, now + L});
      end else if (writes) begin
        exp_q.push_back('{rd, 0, now + 1});
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, $urandom, acc);
  endtask

  // Holds an instruction until accepted, returning the number of stall cycles.
  task automatic present(input logic [31:0] ins, output int stalls);
    bit acc;
    stalls = 0;
    step(1'b1, ins, acc);
    while (!acc && stalls < 20) begin
      stalls++;
      step(1'b1, ins, acc);
    end
    if (!acc) chk("present_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero();
    chk("rst_ready", ready_o, 0);
    chk("rst_alu_issue", alu_issue_o, 0);
    chk("rst_mul_issue", mul_issue_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_sel", wb_sel_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Writeback monitor
  // ---------------------------------------------------------------------------
  initial begin
    int idx;
    forever begin
      @(negedge clk_i);
      if (rsn_i === 1'b1) begin
        idx = -1;
        foreach (exp_q[i]) if (exp_q[i].cyc == cyc) idx = i;
        if (wb_valid_o === 1'b1) begin
          if (idx >= 0) begin
            chk("wb_rd", wb_rd_o, exp_q[idx].rd);
            chk("wb_sel", wb_sel_o, exp_q[idx].sel);
          end else begin
            chk("wb_unexpected", wb_valid_o, 0);
          end
        end else if (idx >= 0) begin
          chk("wb_missing", wb_valid_o, 1);
        end
        if (idx >= 0) exp_q.delete(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          st;
    bit          acc, last_acc, last_v;
    logic [31:0] ins, last_ins;
    logic        v;

    rsn_i   = 1'b0;
    valid_i = 1'b0;
    instr_i = 32'd0;
    repeat (2) @(negedge clk_i);
    chk_all_zero();
    @(posedge clk_i);
    #1 rsn_i = 1'b1;
    idle(2);

    // Single-cycle op: writeback one cycle after issue.
    present(i_addi(5'd5, 5'd0, 12'd7), st);
    chk("addi_stalls", st, 0);
    idle(3);

    // Lone MUL: busy for L cycles, writeback at t+L.
    present(i_mul(5'd3, 5'd1, 5'd2), st);
    chk("mul_stalls", st, 0);
    idle(5);

    // Independent ADD right after a MUL writes back before it.
    present(i_mul(5'd3, 5'd1, 5'd2), st);
    present(i_add(5'd4, 5'd1, 5'd2), st);
    chk("add_t1_stalls", st, 0);
    idle(5);

    // ADD offered two cycles later would collide on the writeback port.
    present(i_mul(5'd3, 5'd1, 5'd2), st);
    idle(1);
    present(i_add(5'd4, 5'd1, 5'd2), st);
    chk("wb_conflict_stalls", st, 1);
    idle(5);

    // RAW on the MUL result: held through the MUL writeback cycle.
    present(i_mul(5'd3, 5'd1, 5'd2), st);
    present(i_add(5'd6, 5'd3, 5'd1), st);
    chk("raw_stalls", st, 3);
    idle(5);

    // WAW: later writer of the same rd waits for the MUL to leave.
    present(i_mul(5'd7, 5'd1, 5'd2), st);
    present(i_addi(5'd7, 5'd0, 12'd1), st);
    chk("waw_stalls", st, 3);
    idle(5);

    // Four back-to-back MULs issue every cycle.
    for (int i = 0; i < 4; i++) begin
      present(i_mul(5'(10 + i), 5'd1, 5'd2), st);
      chk("mul_burst_stalls", st, 0);
    end
    idle(6);

    // Reset with two MULs in flight: everything discarded.
    present(i_mul(5'd3, 5'd1, 5'd2), st);
    present(i_mul(5'd4, 5'd1, 5'd2), st);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    #2 rsn_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero();
    mq.delete();
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(posedge clk_i);
    #1 rsn_i = 1'b1;
    idle(6);

    // Randomized traffic over a small register set to provoke hazards.
    last_acc = 1'b1;
    last_v   = 1'b0;
    last_ins = 32'd0;
    for (int n = 0; n < 600; n++) begin
      if (last_v && !last_acc && $urandom_range(0, 3) != 0) ins = last_ins;
      else ins = rand_instr();
      v = ($urandom_range(0, 9) < 8);
      step(v, ins, acc);
      last_acc = acc;
      last_v   = v;
      last_ins = ins;
    end
    idle(L + 3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
